// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Purpose  : Shared types for the unified memory port arbiter: the buffered
//            request record, the arbiter state encoding and small helpers.
// Contents : mem_req_t        - addr / rmask / wmask / wdata of one request
//            mem_arb_state_t  - IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D
//            c_streak_w       - width of the dmem grant streak counter
//            req_active()     - true when a request record carries any mask
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
   } mem_req_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE_I = 3'd1,
      ST_ISSUE_D = 3'd2,
      ST_WAIT_I  = 3'd3,
      ST_WAIT_D  = 3'd4
   } mem_arb_state_t;

   // Streak counter width covers the full legal STARVE_LIMIT range (1..15).
   localparam int c_streak_w = 4;

   function automatic logic req_active(input mem_req_t r);
      return (r.rmask | r.wmask) != 4'h0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : One memory-port bundle (request + response). Used for the cpu
//            instruction port, the cpu data port and the unified memory port.
// Ports    : addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0] - request
//            rdata[31:0], resp                                 - response
// Modports : master - issues requests, receives responses
//            slave  - receives requests, returns responses
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
   logic [31:0] addr;
   logic [3:0]  rmask;
   logic [3:0]  wmask;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        resp;

   modport master (output addr, output rmask, output wmask, output wdata,
                   input  rdata, input  resp);
   modport slave  (input  addr, input  rmask, input  wmask, input  wdata,
                   output rdata, output resp);
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_req_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_buffer
// Purpose  : One-entry holding register (valid + mem_req_t) for a requester.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            i_capture    - load i_req and set valid at the next edge
//            i_clear      - drop the entry at the next edge (wins over capture)
//            i_req        - request to capture
//            o_valid      - entry is occupied
//            o_req        - stored request
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_buffer
   import mem_port_arbiter_pkg::*;
(
   input  wire logic     clk,
   input  wire logic     rst,
   input  wire logic     i_capture,
   input  wire logic     i_clear,
   input  wire mem_req_t i_req,
   output logic          o_valid,
   output mem_req_t      o_req
);

   logic     valid_q, valid_d;
   mem_req_t req_q,   req_d;

   always_comb begin
      valid_d = valid_q;
      req_d   = req_q;
      if (i_clear) begin
         valid_d = 1'b0;
      end else if (i_capture) begin
         valid_d = 1'b1;
         req_d   = i_req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         req_q   <= '0;
      end else begin
         valid_q <= valid_d;
         req_q   <= req_d;
      end
   end

   assign o_valid = valid_q;
   assign o_req   = req_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one unified memory port between the cpu instruction port
//            (imem) and data port (dmem). One pending request is buffered per
//            requester, one transaction is granted at a time and the response
//            is routed back to its owner. dmem has priority; after
//            STARVE_LIMIT consecutive dmem grants with imem waiting, imem wins.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            imem (slave)   - fetch port, request = rmask != 0
//            dmem (slave)   - data port, request = (rmask | wmask) != 0
//            mem  (master)  - unified port; masks pulse one cycle, addr/wdata
//                             held until resp
//            perf_igrant, perf_dgrant, perf_conflict (32 each) - only when
//                             MEM_ARB_PERF_CNT_EN is defined
// Config   : MEM_ARB_PERF_CNT_EN - adds grant / conflict performance counters
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   mem_port_arbiter_if.slave  imem,
   mem_port_arbiter_if.slave  dmem,
   mem_port_arbiter_if.master mem
`ifdef MEM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]        perf_igrant,
   output logic [31:0]        perf_dgrant,
   output logic [31:0]        perf_conflict
`endif
);

   localparam logic [c_streak_w-1:0] c_limit = c_streak_w'(STARVE_LIMIT);

   mem_arb_state_t        state_q, state_d;
   mem_req_t              grant_q, grant_d;
   logic [c_streak_w-1:0] streak_q, streak_d;

   logic     w_i_new, w_d_new;
   logic     w_i_busy, w_d_busy;
   logic     w_i_valid, w_d_valid;
   mem_req_t w_i_in, w_d_in;
   mem_req_t w_i_req, w_d_req;

   // ------------------------------------------------------------------------
   // Request capture. A requester is busy while its buffer is full or its
   // transaction is in flight; the WAIT cycle carrying mem.resp is no longer
   // busy, so a new request in the same cycle as its own response is taken.
   // ------------------------------------------------------------------------
   always_comb begin
      w_i_new  = imem.rmask != 4'h0;
      w_d_new  = (dmem.rmask | dmem.wmask) != 4'h0;
      w_i_busy = w_i_valid || (state_q == ST_ISSUE_I) ||
                 ((state_q == ST_WAIT_I) && !mem.resp);
      w_d_busy = w_d_valid || (state_q == ST_ISSUE_D) ||
                 ((state_q == ST_WAIT_D) && !mem.resp);

      // Fetches never write, so the write fields are forced quiet.
      w_i_in       = '0;
      w_i_in.addr  = imem.addr;
      w_i_in.rmask = imem.rmask;

      w_d_in       = '0;
      w_d_in.addr  = dmem.addr;
      w_d_in.rmask = dmem.rmask;
      w_d_in.wmask = dmem.wmask;
      w_d_in.wdata = dmem.wdata;
   end

   mem_req_buffer u_ibuf (
      .clk       (clk),
      .rst       (rst),
      .i_capture (w_i_new && !w_i_busy),
      .i_clear   (state_q == ST_ISSUE_I),
      .i_req     (w_i_in),
      .o_valid   (w_i_valid),
      .o_req     (w_i_req)
   );

   mem_req_buffer u_dbuf (
      .clk       (clk),
      .rst       (rst),
      .i_capture (w_d_new && !w_d_busy),
      .i_clear   (state_q == ST_ISSUE_D),
      .i_req     (w_d_in),
      .o_valid   (w_d_valid),
      .o_req     (w_d_req)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         streak_q <= streak_d;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (w_i_valid && w_d_valid) begin
               state_d = (streak_q == c_limit) ? ST_ISSUE_I : ST_ISSUE_D;
            end else if (w_i_valid) begin
               state_d = ST_ISSUE_I;
            end else if (w_d_valid) begin
               state_d = ST_ISSUE_D;
            end
         end
         ST_ISSUE_I: state_d = ST_WAIT_I;
         ST_ISSUE_D: state_d = ST_WAIT_D;
         ST_WAIT_I,
         ST_WAIT_D: begin
            if (mem.resp) begin
               state_d = ST_IDLE;
            end
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Grant register and starvation streak. The granted request is latched on
   // the IDLE->ISSUE transition so addr/wdata stay stable through the whole
   // transaction even after the buffer is freed.
   // ------------------------------------------------------------------------
   always_comb begin
      grant_d = grant_q;
      if (state_q == ST_IDLE) begin
         if (state_d == ST_ISSUE_I) begin
            grant_d = w_i_req;
         end else if (state_d == ST_ISSUE_D) begin
            grant_d = w_d_req;
         end
      end

      streak_d = streak_q;
      if ((state_q == ST_ISSUE_I) || !w_i_valid) begin
         streak_d = '0;
      end else if ((state_q == ST_ISSUE_D) && (streak_q != c_limit)) begin
         streak_d = streak_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      mem.addr  = grant_q.addr;
      mem.wdata = grant_q.wdata;
      mem.rmask = 4'h0;
      mem.wmask = 4'h0;
      if ((state_q == ST_ISSUE_I) || (state_q == ST_ISSUE_D)) begin
         mem.rmask = grant_q.rmask;
         mem.wmask = grant_q.wmask;
      end

      // Responses outside WAIT_* (stale or post-reset) are swallowed here.
      imem.resp  = mem.resp && (state_q == ST_WAIT_I);
      dmem.resp  = mem.resp && (state_q == ST_WAIT_D);
      imem.rdata = mem.rdata;
      dmem.rdata = mem.rdata;
   end

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_igrant_q,   perf_igrant_d;
   logic [31:0] perf_dgrant_q,   perf_dgrant_d;
   logic [31:0] perf_conflict_q, perf_conflict_d;

   always_comb begin
      perf_igrant_d   = perf_igrant_q;
      perf_dgrant_d   = perf_dgrant_q;
      perf_conflict_d = perf_conflict_q;
      if (state_q == ST_ISSUE_I) perf_igrant_d = perf_igrant_q + 32'd1;
      if (state_q == ST_ISSUE_D) perf_dgrant_d = perf_dgrant_q + 32'd1;
      if ((state_q == ST_IDLE) && w_i_valid && w_d_valid) begin
         perf_conflict_d = perf_conflict_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_igrant_q   <= '0;
         perf_dgrant_q   <= '0;
         perf_conflict_q <= '0;
      end else begin
         perf_igrant_q   <= perf_igrant_d;
         perf_dgrant_q   <= perf_dgrant_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_igrant   = perf_igrant_q;
   assign perf_dgrant   = perf_dgrant_q;
   assign perf_conflict = perf_conflict_q;
`endif

`ifndef SYNTHESIS
   // Protocol checks: a new request while the same requester is still busy
   // is dropped by the capture logic above; fetches must never write.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(w_i_new && w_i_busy));
         assert (!(w_d_new && w_d_busy));
         assert (imem.wmask == 4'h0);
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Directed stimulus
//            pushes the expected unified-port requests and routed responses
//            into queues; a negedge monitor pops and compares whenever the
//            DUT presents a request or a response.
// Config   : MEM_ARB_PERF_CNT_EN - also connects and checks perf counters
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int STARVE_LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_port_arbiter_if imem_if ();
   mem_port_arbiter_if dmem_if ();
   mem_port_arbiter_if mem_if  ();

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_igrant, perf_dgrant, perf_conflict;
`endif

   mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (imem_if),
      .dmem          (dmem_if),
      .mem           (mem_if)
`ifdef MEM_ARB_PERF_CNT_EN
      ,
      .perf_igrant   (perf_igrant),
      .perf_dgrant   (perf_dgrant),
      .perf_conflict (perf_conflict)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   mem_req_t    exp_mem[$];
   logic [31:0] exp_i[$];
   logic [31:0] exp_d[$];
   logic        outstanding = 1'b0;
   mem_req_t    held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_mem(input logic [31:0] a, input logic [3:0] r,
                           input logic [3:0] w, input logic [31:0] d);
      mem_req_t t;
      t.addr = a; t.rmask = r; t.wmask = w; t.wdata = d;
      exp_mem.push_back(t);
   endtask

   // Advance to just after the next rising edge; request and response
   // pulses set after a tick therefore last exactly one cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      imem_if.rmask = 4'h0;
      dmem_if.rmask = 4'h0;
      dmem_if.wmask = 4'h0;
      mem_if.resp   = 1'b0;
   endtask

   task automatic req_i(input logic [31:0] a);
      imem_if.addr  = a;
      imem_if.rmask = 4'hF;
   endtask

   task automatic req_d(input logic [31:0] a, input logic [3:0] r,
                        input logic [3:0] w, input logic [31:0] d);
      dmem_if.addr  = a;
      dmem_if.rmask = r;
      dmem_if.wmask = w;
      dmem_if.wdata = d;
   endtask

   // Every grant in this bench follows its trigger (request or previous
   // mem.resp) by exactly two cycles: one to capture / return to IDLE, one
   // to move into ISSUE.
   task automatic wait_grant();
      int n = 0;
      do begin
         tick();
         n++;
      end while (((mem_if.rmask | mem_if.wmask) == 4'h0) && (n < 20));
      check("grant_latency", 32'(n), 32'd2);
   endtask

   // Memory model: respond after lat cycles with rdata = {addr[15:0], 0x0013}.
   task automatic serve(input int lat);
      for (int i = 0; i < lat; i++) tick();
      mem_if.rdata = {mem_if.addr[15:0], 16'h0013};
      mem_if.resp  = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_mem_rmask"}, 32'(mem_if.rmask), 32'h0);
      check({tag, "_mem_wmask"}, 32'(mem_if.wmask), 32'h0);
      check({tag, "_mem_addr"},  mem_if.addr,       32'h0);
      check({tag, "_mem_wdata"}, mem_if.wdata,      32'h0);
      check({tag, "_imem_resp"}, 32'(imem_if.resp), 32'h0);
      check({tag, "_dmem_resp"}, 32'(dmem_if.resp), 32'h0);
   endtask

   // ------------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------------
   always @(negedge clk) begin
      mem_req_t e;
      if (rst) begin
         outstanding = 1'b0;
      end else begin
         if (mem_if.resp && outstanding) begin
            check("mem_addr_held",  mem_if.addr,  held.addr);
            check("mem_wdata_held", mem_if.wdata, held.wdata);
            outstanding = 1'b0;
         end
         if ((mem_if.rmask | mem_if.wmask) != 4'h0) begin
            held.addr  = mem_if.addr;
            held.rmask = mem_if.rmask;
            held.wmask = mem_if.wmask;
            held.wdata = mem_if.wdata;
            outstanding = 1'b1;
            if (exp_mem.size() == 0) begin
               check("mem_req_unexpected", 32'h1, 32'h0);
            end else begin
               e = exp_mem.pop_front();
               check("mem_addr",  mem_if.addr,        e.addr);
               check("mem_rmask", 32'(mem_if.rmask),  32'(e.rmask));
               check("mem_wmask", 32'(mem_if.wmask),  32'(e.wmask));
               check("mem_wdata", mem_if.wdata,       e.wdata);
            end
         end
         if (imem_if.resp) begin
            if (exp_i.size() == 0) check("imem_resp_unexpected", 32'h1, 32'h0);
            else                   check("imem_rdata", imem_if.rdata, exp_i.pop_front());
         end
         if (dmem_if.resp) begin
            if (exp_d.size() == 0) check("dmem_resp_unexpected", 32'h1, 32'h0);
            else                   check("dmem_rdata", dmem_if.rdata, exp_d.pop_front());
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      imem_if.addr  = '0; imem_if.rmask = '0; imem_if.wmask = '0; imem_if.wdata = '0;
      dmem_if.addr  = '0; dmem_if.rmask = '0; dmem_if.wmask = '0; dmem_if.wdata = '0;
      mem_if.rdata  = '0; mem_if.resp   = 1'b0;

      rst = 1'b1;
      repeat (3) tick();
      check_idle_outputs("reset");
      rst = 1'b0;
      tick();

      // Lone fetch
      push_mem(32'h6000_0000, 4'hF, 4'h0, 32'h0);
      exp_i.push_back(32'h0000_0013);
      req_i(32'h6000_0000);
      wait_grant(); serve(1);
      tick(); tick();

      // Simultaneous fetch and store: store first, fetch after its resp
      push_mem(32'h0000_1000, 4'h0, 4'h3, 32'h0000_BEEF);
      push_mem(32'h6000_0004, 4'hF, 4'h0, 32'h0);
      exp_d.push_back(32'h1000_0013);
      exp_i.push_back(32'h0004_0013);
      req_i(32'h6000_0004);
      req_d(32'h0000_1000, 4'h0, 4'h3, 32'h0000_BEEF);
      wait_grant(); serve(2);
      wait_grant(); serve(1);
      tick(); tick();

      // Starvation guard: 4 dmem grants, then the waiting fetch
      push_mem(32'h0000_2000, 4'hF, 4'h0, 32'h0);
      push_mem(32'h0000_2004, 4'hF, 4'h0, 32'h0);
      push_mem(32'h0000_2008, 4'hF, 4'h0, 32'h0);
      push_mem(32'h0000_200C, 4'hF, 4'h0, 32'h0);
      push_mem(32'h6000_0008, 4'hF, 4'h0, 32'h0);
      push_mem(32'h0000_2010, 4'hF, 4'h0, 32'h0);
      exp_d.push_back(32'h2000_0013);
      exp_d.push_back(32'h2004_0013);
      exp_d.push_back(32'h2008_0013);
      exp_d.push_back(32'h200C_0013);
      exp_i.push_back(32'h0008_0013);
      exp_d.push_back(32'h2010_0013);
      req_i(32'h6000_0008);
      req_d(32'h0000_2000, 4'hF, 4'h0, 32'h0);
      for (int k = 0; k < 6; k++) begin
         wait_grant(); serve(1);
         if (k < 4) req_d(32'h0000_2004 + 32'(4 * k), 4'hF, 4'h0, 32'h0);
      end
      tick(); tick();

      // Stale response in IDLE
      mem_if.rdata = 32'hDEAD_BEEF;
      mem_if.resp  = 1'b1;
      check("stale_imem_resp", 32'(imem_if.resp), 32'h0);
      check("stale_dmem_resp", 32'(dmem_if.resp), 32'h0);
      tick(); tick();

      // Reset while in WAIT_D; the late response must be ignored
      push_mem(32'h0000_3000, 4'h0, 4'hF, 32'h1234_5678);
      req_d(32'h0000_3000, 4'h0, 4'hF, 32'h1234_5678);
      wait_grant();
      tick();
      rst = 1'b1;
      tick();
      check_idle_outputs("midrst");
      rst = 1'b0;
      tick(); tick();
      mem_if.rdata = 32'h0BAD_0BAD;
      mem_if.resp  = 1'b1;
      check("post_rst_imem_resp", 32'(imem_if.resp), 32'h0);
      check("post_rst_dmem_resp", 32'(dmem_if.resp), 32'h0);
      repeat (4) tick();

      // Mixed traffic with conflicts; also re-request in own resp cycle
      push_mem(32'h0000_4000, 4'h1, 4'h0, 32'h0);
      push_mem(32'h0000_4004, 4'h1, 4'h0, 32'h0);
      push_mem(32'h6000_000C, 4'hF, 4'h0, 32'h0);
      push_mem(32'h0000_4008, 4'h0, 4'hF, 32'hCAFE_F00D);
      push_mem(32'h6000_0010, 4'hF, 4'h0, 32'h0);
      exp_d.push_back(32'h4000_0013);
      exp_d.push_back(32'h4004_0013);
      exp_i.push_back(32'h000C_0013);
      exp_d.push_back(32'h4008_0013);
      exp_i.push_back(32'h0010_0013);
      req_i(32'h6000_000C);
      req_d(32'h0000_4000, 4'h1, 4'h0, 32'h0);
      wait_grant(); serve(1);
      req_d(32'h0000_4004, 4'h1, 4'h0, 32'h0);
      wait_grant(); serve(1);
      wait_grant(); serve(1);
      req_i(32'h6000_0010);
      req_d(32'h0000_4008, 4'h0, 4'hF, 32'hCAFE_F00D);
      wait_grant(); serve(1);
      wait_grant(); serve(1);
      repeat (3) tick();

`ifdef MEM_ARB_PERF_CNT_EN
      // Counters were cleared by the mid-transaction reset.
      check("perf_igrant",   perf_igrant,   32'd2);
      check("perf_dgrant",   perf_dgrant,   32'd3);
      check("perf_conflict", perf_conflict, 32'd3);
`endif

      check("exp_mem_left", 32'(exp_mem.size()), 32'd0);
      check("exp_i_left",   32'(exp_i.size()),   32'd0);
      check("exp_d_left",   32'(exp_d.size()),   32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
